vending_fsm_param: RTL
======================

Name: vending_fsm_param

Overview:
Parametrised successor to the fixed four-item vending FSM. It accumulates coin credit on a single clock and accepts or rejects item selections against a configurable price table. On a vend it issues a dispense pulse, then returns change over a valid/ready handshake. Cancel/refund, credit capping and explicit reject/nack flags are included; the block sits between the coin acceptor / keypad front end and the dispenser / change-hopper drivers.

Parameters:
NUM_ITEMS, 4, number of selectable items (2..16)
CREDIT_W, 8, width of credit, price and change values
PRICE_LIST, 32'h140F0A05, packed prices; item i at bits [i*CREDIT_W +: CREDIT_W]; default item0=5, item1=10, item2=15, item3=20
MAX_CREDIT, 40, highest credit the machine will hold
SEL_W, 2, width of item index (>= clog2(NUM_ITEMS))
TIMEOUT_CYCLES, 1000, inactivity refund limit (used only with VEND_TIMEOUT_EN)

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
coin_valid  in  1  coin present this cycle
coin_val  in  CREDIT_W  coin value; accepted denominations are 5, 10 and 20
sel_valid  in  1  selection strobe
sel_item  in  SEL_W  selected item index
cancel  in  1  refund request
change_ready  in  1  hopper accepts change_amt
credit  out  CREDIT_W  current credit
coin_reject  out  1  one-cycle pulse: coin returned
sel_nack  out  1  one-cycle pulse: selection refused
dispense  out  1  one-cycle vend pulse
dispense_item  out  SEL_W  item being dispensed, valid with dispense
change_valid  out  1  change_amt valid, held until change_ready
change_amt  out  CREDIT_W  change or refund value
state  out  2  IDLE=0, CREDIT=1, VEND=2, CHANGE=3

Behaviour:
- All outputs are registered. Reset (rst_n low, asynchronous) forces state=IDLE and clears every output to 0. Reset asserted mid-transaction discards credit with no refund.
- Coin handling (IDLE or CREDIT):
  - A coin is accepted only if coin_val is 5, 10 or 20 and credit+coin_val <= MAX_CREDIT.
  - An accepted coin makes credit update on the next edge; IDLE moves to CREDIT.
  - Otherwise coin_reject pulses on the next cycle and credit is unchanged.
  - Coins arriving in VEND or CHANGE are always rejected.
- Priority within a cycle in CREDIT is cancel > sel_valid > coin_valid. A coin arriving in the same cycle as an accepted cancel or selection is rejected.
- CREDIT, cancel: change_amt<=credit, credit<=0, go to CHANGE.
- CREDIT, sel_valid:
  - sel_item < NUM_ITEMS and credit >= price: latch item, go to VEND.
  - Otherwise sel_nack pulses, state and credit unchanged.
- IDLE: sel_valid gives sel_nack; cancel is ignored.
- VEND lasts exactly one cycle:
  - dispense=1 with dispense_item; change_amt<=credit-price; credit<=0.
  - Next state is CHANGE if the difference is nonzero, else IDLE.
  - Latency from accepted selection to dispense is 1 cycle.
- CHANGE:
  - change_valid=1, and change_amt is held stable until change_ready is sampled high.
  - Then change_valid<=0, change_amt<=0, go to IDLE.
  - change_ready asserted in the first CHANGE cycle completes in that cycle.
  - sel_valid and cancel are ignored in CHANGE.
- Arithmetic is unsigned at CREDIT_W. The cap check guarantees no overflow, provided MAX_CREDIT+20 < 2^CREDIT_W.
- A price of 0 vends on any selection made in CREDIT.

Optional Feature:
VEND_TIMEOUT_EN
- Defined:
  - A counter runs in CREDIT and clears on any accepted coin or selection attempt.
  - On reaching TIMEOUT_CYCLES it forces a refund, identical to cancel (CHANGE with change_amt=credit).
  - The counter clears on exit from CREDIT.
- Undefined: no counter is built; credit is held indefinitely.

Test Plan:
- Reset, then coins 5,10 and select item1 (price 10) -> credit 15, dispense=1 with dispense_item=1 one cycle after selection, change_valid=1 with change_amt=5, IDLE after change_ready.
- Coins 20,20 and select item3 (price 20) -> dispense, change_amt=20; hold change_ready low 5 cycles -> change_amt stable 20 throughout.
- Credit 5, select item2 (price 15) -> sel_nack pulse, credit stays 5; then coin 10 and reselect -> dispense, no CHANGE, back to IDLE.
- Credit 40, coin 5 -> coin_reject, credit 40; coin_val=7 in IDLE -> coin_reject, state stays IDLE.
- Credit 25, cancel and coin 10 in the same cycle -> coin_reject, change_amt=25; rst_n pulsed low during CHANGE -> all outputs 0 immediately.
- VEND_TIMEOUT_EN with TIMEOUT_CYCLES=8: coin 10, then idle 8 cycles -> refund change_amt=10. Without the macro: credit still 10 after 100 cycles.

Source files
------------

// File: rtl/vending_fsm_param_if.sv
// Vending controller bus: coin/keypad inputs, dispense and change-hopper outputs.
// Latency: n/a (wiring only).
// Backpressure: change_valid/change_ready handshake toward the hopper.
// Ports: master = front end / bench side (drives coin, selection, cancel,
//        change_ready); slave = vending_fsm_param (drives credit, pulses,
//        dispense, change and state).
interface vending_fsm_param_if #(
    parameter int CREDIT_W = 8,
    parameter int SEL_W    = 2
);
    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_val;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_item;
    logic                cancel;
    logic                change_ready;
    logic [CREDIT_W-1:0] credit;
    logic                coin_reject;
    logic                sel_nack;
    logic                dispense;
    logic [SEL_W-1:0]    dispense_item;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic [1:0]          state;

    modport master (
        output coin_valid, coin_val, sel_valid, sel_item, cancel, change_ready,
        input  credit, coin_reject, sel_nack, dispense, dispense_item,
               change_valid, change_amt, state
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel_item, cancel, change_ready,
        output credit, coin_reject, sel_nack, dispense, dispense_item,
               change_valid, change_amt, state
    );
endinterface

// File: rtl/vending_fsm_param.sv
// Parametrised vending controller: coin credit, price-table vend, change return.
// Latency: accepted selection -> dispense 1 cycle; all outputs registered.
// Backpressure: change_amt held with change_valid until change_ready is sampled.
// Ports: clk, rst_n (async active-low), bus (vending_fsm_param_if.slave).
// Optional build macro VEND_TIMEOUT_EN adds an inactivity refund in CREDIT
// after TIMEOUT_CYCLES quiet cycles; without it credit is held indefinitely.
module vending_fsm_param #(
    parameter int                            NUM_ITEMS      = 4,
    parameter int                            CREDIT_W       = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST     = 32'h140F0A05,
    parameter int                            MAX_CREDIT     = 40,
    parameter int                            SEL_W          = 2,
    parameter int                            TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    vending_fsm_param_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic [SEL_W-1:0]    dispense_item_q, dispense_item_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_nack_q, sel_nack_d;
    logic                dispense_q, dispense_d;
    logic                change_valid_q, change_valid_d;

    // Loop lookup keeps out-of-range indices from slicing past PRICE_LIST.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        price_of = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (32'(idx) == 32'(i)) price_of = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
        end
    endfunction

    logic [CREDIT_W:0]   coin_sum;
    logic                coin_denom_ok, coin_ok;
    logic                sel_ok;
    logic [CREDIT_W-1:0] vend_diff;
    logic                tmo_hit;

    assign coin_denom_ok = (bus.coin_val == CREDIT_W'(5)) ||
                           (bus.coin_val == CREDIT_W'(10)) ||
                           (bus.coin_val == CREDIT_W'(20));
    // One extra bit so the cap compare cannot wrap.
    assign coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin_val};
    assign coin_ok   = bus.coin_valid && coin_denom_ok &&
                       (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign sel_ok    = bus.sel_valid && (32'(bus.sel_item) < 32'(NUM_ITEMS)) &&
                       (credit_q >= price_of(bus.sel_item));
    // dispense_item_q holds the latched selection for the single VEND cycle.
    assign vend_diff = credit_q - price_of(dispense_item_q);

`ifdef VEND_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             activity;

    // A rejected coin is not activity; any selection attempt is.
    assign activity = coin_ok || bus.sel_valid;
    assign tmo_hit  = (state_q == S_CREDIT) && !activity &&
                      (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (state_q != S_CREDIT || activity || tmo_hit) tmo_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;
    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        change_amt_d    = change_amt_q;
        change_valid_d  = change_valid_q;
        dispense_item_d = '0;
        coin_reject_d   = 1'b0;
        sel_nack_d      = 1'b0;
        dispense_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                sel_nack_d = bus.sel_valid;
                if (coin_ok) begin
                    credit_d = coin_sum[CREDIT_W-1:0];
                    state_d  = S_CREDIT;
                end else begin
                    coin_reject_d = bus.coin_valid;
                end
            end
            S_CREDIT: begin
                if (bus.cancel || tmo_hit) begin
                    change_amt_d   = credit_q;
                    change_valid_d = 1'b1;
                    credit_d       = '0;
                    coin_reject_d  = bus.coin_valid;
                    state_d        = S_CHANGE;
                end else if (sel_ok) begin
                    dispense_d      = 1'b1;
                    dispense_item_d = bus.sel_item;
                    coin_reject_d   = bus.coin_valid;
                    state_d         = S_VEND;
                end else begin
                    // A refused selection does not block a coin in the same cycle.
                    sel_nack_d = bus.sel_valid;
                    if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
                    else         coin_reject_d = bus.coin_valid;
                end
            end
            S_VEND: begin
                credit_d       = '0;
                change_amt_d   = vend_diff;
                change_valid_d = (vend_diff != '0);
                coin_reject_d  = bus.coin_valid;
                state_d        = (vend_diff != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                if (bus.change_ready) begin
                    change_valid_d = 1'b0;
                    change_amt_d   = '0;
                    state_d        = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            credit_q        <= '0;
            change_amt_q    <= '0;
            change_valid_q  <= 1'b0;
            dispense_item_q <= '0;
            coin_reject_q   <= 1'b0;
            sel_nack_q      <= 1'b0;
            dispense_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            change_amt_q    <= change_amt_d;
            change_valid_q  <= change_valid_d;
            dispense_item_q <= dispense_item_d;
            coin_reject_q   <= coin_reject_d;
            sel_nack_q      <= sel_nack_d;
            dispense_q      <= dispense_d;
        end
    end

    assign bus.state         = state_q;
    assign bus.credit        = credit_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.sel_nack      = sel_nack_q;
    assign bus.dispense      = dispense_q;
    assign bus.dispense_item = dispense_item_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.change_amt    = change_amt_q;
endmodule
